// File: rtl/halfband_pkg.sv
// Shared definitions for the halfband interpolator: coefficient format,
// odd-phase coefficient table and the output phase encoding.
package halfband_pkg;

  localparam int COEF_WIDTH = 16;
  localparam int COEF_FRAC  = 15;
  localparam int MAX_PAIRS  = 8;

  typedef logic signed [COEF_WIDTH-1:0] coef_t;

  // Odd-phase (midpoint) coefficients, Q1.15, centre-outwards. These entries
  // are the 4-pair design. They sum to 16384 (0.5), so the polyphase DC gain
  // is 1. A different pair count needs its own table loaded here.
  localparam coef_t HB_INTERP_COEF [0:MAX_PAIRS-1] = '{
    16'sd20126, -16'sd4686, 16'sd1304, -16'sd360,
    16'sd0,     16'sd0,     16'sd0,    16'sd0
  };

  // EVEN: the direct sample is on the output; ODD: the midpoint is.
  typedef enum logic {PH_EVEN, PH_ODD} phase_t;

endpackage

// File: rtl/halfband_pair_mac.sv
// Odd-phase arithmetic of the halfband interpolator. Folds each symmetric
// tap pair, multiplies by its coefficient, sums the products at full
// precision, rounds half-up and reduces to the sample width.
// Build option HALFBAND_INTERP_SAT_EN: saturate the rounded result instead
// of wrapping it.
module halfband_pair_mac
  import halfband_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_PAIRS = 4
) (
  input  logic [2*NUM_PAIRS*WIDTH-1:0] taps,  // x[0] in the low WIDTH bits
  output logic [WIDTH-1:0]             odd
);

  localparam int PAIR_W = WIDTH + 1;
  localparam int PROD_W = PAIR_W + COEF_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NUM_PAIRS);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t ROUND_BIAS = acc_t'(1) << (COEF_FRAC - 1);

  logic signed [PROD_W-1:0] prod [NUM_PAIRS];
  acc_t                     acc;
  acc_t                     rounded;

  // Pair k joins the taps either side of the centre: x[P-1-k] and x[P+k].
  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
    logic signed [WIDTH-1:0]  near_s;
    logic signed [WIDTH-1:0]  far_s;
    logic signed [PAIR_W-1:0] pair_sum;

    assign near_s   = taps[(NUM_PAIRS-1-k)*WIDTH +: WIDTH];
    assign far_s    = taps[(NUM_PAIRS+k)*WIDTH +: WIDTH];
    // Size casts of signed operands sign-extend, so the sum cannot overflow.
    assign pair_sum = PAIR_W'(near_s) + PAIR_W'(far_s);
    assign prod[k]  = PROD_W'(pair_sum) * PROD_W'(HB_INTERP_COEF[k]);
  end

  // Full-precision sum of all pair products.
  always_comb begin
    // NOTE: every variable driven here gets a value before any conditional
    // or loop use, so no latch can be inferred.
    acc = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      acc = acc + acc_t'(prod[k]);
    end
  end

  assign rounded = (acc + ROUND_BIAS) >>> COEF_FRAC;

`ifdef HALFBAND_INTERP_SAT_EN
  logic overflow;

  assign overflow = (rounded[ACC_W-1:WIDTH-1] != {(ACC_W-WIDTH+1){rounded[ACC_W-1]}});

  // Clamp to the most negative/positive sample when the result does not fit.
  always_comb begin
    odd = rounded[WIDTH-1:0];
    if (overflow) begin
      odd = rounded[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_rounded;

  // Wrap: keep the low WIDTH bits of the rounded result.
  assign odd            = rounded[WIDTH-1:0];
  assign unused_rounded = ^rounded[ACC_W-1:WIDTH];
`endif

endmodule

// File: rtl/halfband_interp.sv
// 2x halfband interpolator. Each accepted input sample produces two output
// samples: the direct (centre-tap) sample, then the interpolated midpoint.
// Valid/ready on both sides; one input per two cycles, one output per cycle.
// Build option HALFBAND_INTERP_SAT_EN: saturate the midpoint sample instead
// of wrapping it.
module halfband_interp
  import halfband_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_PAIRS = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  localparam int NUM_TAPS = 2 * NUM_PAIRS;

  logic [WIDTH-1:0]          x      [NUM_TAPS];
  logic [WIDTH-1:0]          x_next [NUM_TAPS];
  logic [NUM_TAPS*WIDTH-1:0] taps;
  logic [WIDTH-1:0]          odd_result;
  logic [WIDTH-1:0]          odd_hold;
  phase_t                    phase;
  phase_t                    phase_next;
  logic                      in_fire;
  logic                      out_fire;

  assign in_fire  = i_in_valid & o_in_ready;
  assign out_fire = o_out_valid & i_out_ready;

  // Delay line as it will look after this cycle's shift; both output
  // samples of a new input are computed from it.
  always_comb begin
    x_next[0] = i_in_data;
    for (int i = 1; i < NUM_TAPS; i++) begin
      x_next[i] = x[i-1];
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = x_next[g];
  end

  halfband_pair_mac #(
    .WIDTH     (WIDTH),
    .NUM_PAIRS (NUM_PAIRS)
  ) u_pair_mac (
    .taps (taps),
    .odd  (odd_result)
  );

  // Phase state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_reset) begin
      phase <= PH_EVEN;
    end else begin
      phase <= phase_next;
    end
  end

  // Phase transitions: a new input restarts at EVEN; taking the direct
  // sample moves to ODD.
  always_comb begin
    phase_next = phase;
    if (in_fire) begin
      phase_next = PH_EVEN;
    end else if (out_fire && phase == PH_EVEN) begin
      phase_next = PH_ODD;
    end
  end

  // Accept input when the output register is empty or its last sample
  // (the midpoint) leaves this cycle.
  always_comb begin
    o_in_ready = !o_out_valid | ((phase == PH_ODD) & i_out_ready);
  end

  // Delay line, midpoint hold and output register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
      odd_hold    <= '0;
      // NOTE: the delay line is reset on purpose: stale history would leak
      // into the first midpoints after reset.
      for (int i = 0; i < NUM_TAPS; i++) begin
        x[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          x[i] <= x_next[i];
        end
        o_out_data  <= x_next[NUM_PAIRS];
        odd_hold    <= odd_result;
        o_out_valid <= 1'b1;
      end else if (out_fire) begin
        if (phase == PH_EVEN) begin
          o_out_data <= odd_hold;
        end else begin
          o_out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_halfband_interp.sv
// Self-checking bench for halfband_interp (WIDTH=16, NUM_PAIRS=4). A queue of
// pending output samples, computed with plain arithmetic from a sample
// history, predicts every output, valid and ready.
module tb_halfband_interp;

  localparam int WIDTH     = 16;
  localparam int NUM_PAIRS = 4;
  localparam int NTAP      = 2 * NUM_PAIRS;

  logic             i_clock = 1'b0;
  logic             i_reset = 1'b1;
  logic [WIDTH-1:0] i_in_data = '0;
  logic             i_in_valid = 1'b0;
  logic             o_in_ready;
  logic [WIDTH-1:0] o_out_data;
  logic             o_out_valid;
  logic             i_out_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  int exp_q [$];          // outputs still owed by the DUT, front is next
  int got   [$];          // outputs actually taken from the DUT
  int rdy_seq [$];        // observed o_in_ready per cycle
  int hist  [NTAP];       // accepted samples, hist[0] newest
  int ref_coef [NUM_PAIRS] = '{20126, -4686, 1304, -360};

  always #5 i_clock = ~i_clock;

  halfband_interp #(
    .WIDTH     (WIDTH),
    .NUM_PAIRS (NUM_PAIRS)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_in_data   (i_in_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_odd();
    longint s = 0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      s += longint'(ref_coef[k]) * longint'(hist[NUM_PAIRS-1-k] + hist[NUM_PAIRS+k]);
    end
    s = (s + 16384) >>> 15;
`ifdef HALFBAND_INTERP_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`else
    s = s & 64'hFFFF;
    if (s >= 32768) s -= 65536;
`endif
    return int'(s);
  endfunction

  function automatic void clear_model();
    exp_q.delete();
    for (int i = 0; i < NTAP; i++) hist[i] = 0;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input logic vin, input int din, input logic ordy,
                       output logic fired);
    logic m_ready, m_valid, out_f;
    @(negedge i_clock);
    i_in_valid  = vin;
    i_in_data   = WIDTH'(din);
    i_out_ready = ordy;
    #1;
    m_valid = (exp_q.size() > 0);
    m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    rdy_seq.push_back(int'(o_in_ready));
    check("in_ready", 32'(o_in_ready), 32'(m_ready));
    check("out_valid", 32'(o_out_valid), 32'(m_valid));
    if (m_valid) check("out_data", 32'($signed(o_out_data)), exp_q[0]);
    if (o_out_valid === 1'b1 && ordy) got.push_back(int'($signed(o_out_data)));
    fired = vin & m_ready;
    out_f = m_valid & ordy;
    @(posedge i_clock);
    if (fired) begin
      for (int i = NTAP - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = din;
      exp_q.delete();
      exp_q.push_back(hist[NUM_PAIRS]);
      exp_q.push_back(model_odd());
    end else if (out_f) begin
      void'(exp_q.pop_front());
    end
  endtask

  // Offer one sample with downstream always ready, retrying a bounded number of cycles.
  task automatic feed(input int val);
    logic f = 1'b0;
    for (int t = 0; t < 6 && !f; t++) cycle(1'b1, val, 1'b1, f);
    if (!f) begin
      n_cmp++;
      n_fail++;
      $error("FAIL feed_timeout: observed not accepted expected accepted");
    end
  endtask

  task automatic drain(input int n);
    logic f;
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b1, f);
  endtask

  // Assert reset between clock edges and check the outputs clear at once.
  task automatic do_reset();
    @(negedge i_clock);
    #2;
    i_reset = 1'b1;
    #1;
    check("rst_valid", 32'(o_out_valid), 0);
    check("rst_ready", 32'(o_in_ready), 1);
    check("rst_data", 32'($signed(o_out_data)), 0);
    @(negedge i_clock);
    i_in_valid = 1'b0;
    i_reset    = 1'b0;
    clear_model();
  endtask

  initial begin
    logic f;
    int   n_acc;
    int   odd_imp [8] = '{-180, 652, -2343, 10063, 10063, -2343, 652, -180};

    // Reset then idle.
    clear_model();
    do_reset();
    drain(3);

    // Impulse with both sides always ready.
    got.delete();
    rdy_seq.delete();
    cycle(1'b1, 16384, 1'b1, f);
    for (int i = 0; i < 19; i++) cycle(1'b1, 0, 1'b1, f);
    drain(3);
    check("imp_count_ge16", 32'(got.size() >= 16), 1);
    if (got.size() >= 16) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("imp_even%0d", i + 1), got[2*i], (i == 4) ? 16384 : 0);
        check($sformatf("imp_odd%0d", i + 1), got[2*i+1], odd_imp[i]);
      end
    end
    for (int i = 0; i < 10; i++) check($sformatf("rdy_pat%0d", i), rdy_seq[i], (i % 2 == 0) ? 1 : 0);

    // Sustained DC.
    do_reset();
    got.delete();
    for (int i = 0; i < 30; i++) cycle(1'b1, 1000, 1'b1, f);
    for (int i = 16; i < got.size(); i++) begin
      check($sformatf("dc_out%0d", i), 32'((got[i] - 1000 <= 1) && (1000 - got[i] <= 1)), 1);
    end

    // Full-scale alternating pattern: overflow of the midpoint.
    do_reset();
    got.delete();
    feed(-32767); feed(32767); feed(-32767); feed(32767);
    feed(32767);  feed(-32767); feed(32767); feed(-32767);
    drain(4);
    check("ovf_count", got.size(), 16);
    if (got.size() >= 16) begin
`ifdef HALFBAND_INTERP_SAT_EN
      check("ovf_odd8", got[15], 32767);
`else
      check("ovf_odd8", got[15], -12586);
`endif
    end

    // Reset in the middle of a stream.
    for (int i = 0; i < 5; i++) cycle(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b1, f);
    do_reset();
    drain(3);
    got.delete();
    feed(12345);
    drain(3);
    check("post_rst_count", got.size(), 2);
    if (got.size() == 2) check("post_rst_even", got[0], 0);

    // Random valid and ready.
    do_reset();
    got.delete();
    n_acc = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768,
            1'($urandom_range(0, 1)), f);
      if (f) n_acc++;
    end
    drain(4);
    check("rand_two_per_input", got.size(), 2 * n_acc);
    check("rand_some_accepted", 32'(n_acc > 20), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
